// File: rtl/xgmii_rx_deframer.sv
// XGMII 64-bit receive deframer: strips preamble/SFD, realigns lane-4 starts to
// lane 0, and emits a byte-enabled frame stream with good/error frame statistics.
module xgmii_rx_deframer #(
  parameter int unsigned DATA_WIDTH         = 64,
  parameter int unsigned CTRL_WIDTH         = (DATA_WIDTH / 8),
  parameter int unsigned CNT_WIDTH          = 16,
  parameter bit          LANE4_START_ENABLE = 1'b1
) (
  input  logic                  rx_clk,
  input  logic                  rx_rst,
  input  logic [DATA_WIDTH-1:0] xgmii_rxd,
  input  logic [CTRL_WIDTH-1:0] xgmii_rxc,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic [CTRL_WIDTH-1:0] m_tkeep,
  output logic                  m_tvalid,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic [CNT_WIDTH-1:0]  frame_count,
  output logic [CNT_WIDTH-1:0]  error_count,
  output logic                  frame_error
);

  localparam logic [7:0]  C_START  = 8'hFB;
  localparam logic [7:0]  C_TERM   = 8'hFD;
  localparam logic [63:0] L0_START = 64'hD555_5555_5555_55FB;

  typedef enum logic [2:0] {S_IDLE, S_PAY0, S_CHK4, S_PAY4, S_DRAIN} state_t;

  // Index of the lowest set control bit; 8 when the word is all data.
  function automatic logic [3:0] first_ctl(input logic [7:0] c);
    first_ctl = 4'd8;
    for (int i = 7; i >= 0; i--) if (c[i]) first_ctl = 4'(i);
  endfunction

  function automatic logic [7:0] lane_of(input logic [63:0] d, input logic [3:0] idx);
    lane_of = '0;
    for (int i = 0; i < 8; i++) if (4'(i) == idx) lane_of = d[8*i +: 8];
  endfunction

  function automatic logic [7:0] keep_of(input logic [3:0] n);
    logic [8:0] m;
    m = (9'd1 << n) - 9'd1;
    return m[7:0];
  endfunction

  function automatic logic [63:0] mask_data(input logic [63:0] d, input logic [7:0] k);
    for (int i = 0; i < 8; i++) mask_data[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] c, input logic en);
    return (en && (c != '1)) ? c + CNT_WIDTH'(1) : c;
  endfunction

  state_t      r_state, w_state_nxt;
  logic [31:0] r_hold, w_hold_nxt;
  logic [3:0]  r_hold_ctl, w_hold_ctl_nxt;
  logic        r_has_data, w_has_data_nxt;

  logic [63:0] r_tdata;
  logic [7:0]  r_tkeep;
  logic        r_tvalid, r_tlast, r_tuser, r_frame_error;
  logic [CNT_WIDTH-1:0] r_frame_count, r_error_count;

  logic        w_beat, w_last, w_user, w_err_a, w_err_b, w_seek;
  logic [63:0] w_data;
  logic [3:0]  w_nbytes, w_k, w_j;
  logic [7:0]  w_lane_k, w_hold_j, w_keep;

  always_comb begin
    w_state_nxt    = r_state;
    w_hold_nxt     = r_hold;
    w_hold_ctl_nxt = r_hold_ctl;
    w_has_data_nxt = r_has_data;
    w_beat         = 1'b0;
    w_last         = 1'b0;
    w_user         = 1'b0;
    w_err_a        = 1'b0;
    w_err_b        = 1'b0;
    w_seek         = 1'b0;
    w_data         = '0;
    w_nbytes       = 4'd0;
    w_k            = first_ctl(xgmii_rxc);
    w_lane_k       = lane_of(xgmii_rxd, w_k);
    w_j            = first_ctl({4'b0000, r_hold_ctl});
    w_hold_j       = lane_of({32'h0, r_hold}, w_j);

    case (r_state)
      S_IDLE: w_seek = 1'b1;
      S_PAY0: begin
        w_data = xgmii_rxd;
        if (xgmii_rxc == '0) begin
          w_beat         = 1'b1;
          w_nbytes       = 4'd8;
          w_has_data_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          if (w_lane_k == C_TERM) begin
            if ((w_k == 4'd0) && !r_has_data) w_err_a = 1'b1;
            else begin
              w_beat   = 1'b1;
              w_nbytes = w_k;
              w_last   = 1'b1;
            end
          end else begin
            w_beat   = 1'b1;
            w_nbytes = w_k;
            w_last   = 1'b1;
            w_user   = 1'b1;
            w_err_a  = 1'b1;
          end
        end
      end
      S_CHK4: begin
        if ((xgmii_rxc[3:0] == 4'h0) && (xgmii_rxd[31:0] == 32'hD555_5555)) begin
          w_hold_nxt     = xgmii_rxd[63:32];
          w_hold_ctl_nxt = xgmii_rxc[7:4];
          // Control already in the upper half: let DRAIN finish (or reject) the frame.
          w_state_nxt    = (xgmii_rxc[7:4] == 4'h0) ? S_PAY4 : S_DRAIN;
        end else begin
          w_err_a     = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_PAY4: begin
        w_data = {xgmii_rxd[31:0], r_hold};
        if (w_k == 4'd8) begin
          w_beat     = 1'b1;
          w_nbytes   = 4'd8;
          w_hold_nxt = xgmii_rxd[63:32];
        end else if (w_k <= 4'd4) begin
          w_beat      = 1'b1;
          w_nbytes    = 4'd4 + w_k;
          w_last      = 1'b1;
          w_user      = (w_lane_k != C_TERM);
          w_err_a     = (w_lane_k != C_TERM);
          w_state_nxt = S_IDLE;
        end else begin
          w_beat         = 1'b1;
          w_nbytes       = 4'd8;
          w_hold_nxt     = xgmii_rxd[63:32];
          w_hold_ctl_nxt = xgmii_rxc[7:4];
          w_state_nxt    = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_data      = {32'h0, r_hold};
        w_seek      = 1'b1;
        w_state_nxt = S_IDLE;
        if ((w_hold_j == C_TERM) && (w_j == 4'd0)) w_err_a = 1'b1;
        else begin
          w_beat   = 1'b1;
          w_nbytes = w_j;
          w_last   = 1'b1;
          w_user   = (w_hold_j != C_TERM);
          w_err_a  = (w_hold_j != C_TERM);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Start detection on words outside a frame (including the DRAIN word).
    if (w_seek) begin
      if (xgmii_rxc[0] && (xgmii_rxd[7:0] == C_START)) begin
        if ((xgmii_rxc == 8'h01) && (xgmii_rxd == L0_START)) begin
          w_state_nxt    = S_PAY0;
          w_has_data_nxt = 1'b0;
        end else w_err_b = 1'b1;
      end else if ((LANE4_START_ENABLE != 1'b0) && xgmii_rxc[4] && (xgmii_rxd[39:32] == C_START)) begin
        if ((xgmii_rxc[7:4] == 4'b0001) && (xgmii_rxd[63:40] == 24'h55_5555)) w_state_nxt = S_CHK4;
        else w_err_b = 1'b1;
      end
    end
  end

  assign w_keep = w_beat ? keep_of(w_nbytes) : 8'h00;

  always_ff @(posedge rx_clk or negedge rx_rst) begin
    if (!rx_rst) begin
      r_state       <= S_IDLE;
      r_hold        <= '0;
      r_hold_ctl    <= '0;
      r_has_data    <= 1'b0;
      r_tdata       <= '0;
      r_tkeep       <= '0;
      r_tvalid      <= 1'b0;
      r_tlast       <= 1'b0;
      r_tuser       <= 1'b0;
      r_frame_error <= 1'b0;
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_hold        <= w_hold_nxt;
      r_hold_ctl    <= w_hold_ctl_nxt;
      r_has_data    <= w_has_data_nxt;
      r_tdata       <= mask_data(w_data, w_keep);
      r_tkeep       <= w_keep;
      r_tvalid      <= w_beat;
      r_tlast       <= w_beat & w_last;
      r_tuser       <= w_beat & w_user;
      r_frame_error <= w_err_a | w_err_b;
      r_frame_count <= sat_inc(r_frame_count, w_beat & w_last & ~w_user);
      r_error_count <= sat_inc(sat_inc(r_error_count, w_err_a), w_err_b);
    end
  end

  assign m_tdata     = r_tdata;
  assign m_tkeep     = r_tkeep;
  assign m_tvalid    = r_tvalid;
  assign m_tlast     = r_tlast;
  assign m_tuser     = r_tuser;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
  assign frame_error = r_frame_error;

endmodule
